// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared frame-RAM widths and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int c_ADDR_W = 15;
    localparam int c_DATA_W = 24;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/vram_port_sched_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word-fall-through head output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A full FIFO refuses the push even when the same cycle pops.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : vram_port_sched
// Description : Frame-RAM port arbiter: VGA reads first, buffered writes, clear.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_port_sched
    import vram_pkg::*;
#(
    parameter int                ADDR_W      = c_ADDR_W,
    parameter int                DATA_W      = c_DATA_W,
    parameter int                FRAME_WORDS = 19200,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_restart,
    input  logic              clear_start,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              clear_done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam int                c_CNT_W     = $clog2(FIFO_DEPTH + 1);

    sched_state_e      r_state;
    sched_state_e      w_next_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_rd_pend;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_frame_done;
    logic              r_clear_done;
    logic              r_overflow;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic              w_push;
    logic              w_pop;
    logic              w_clr_wr;
    logic              w_clr_last;
    logic              w_wr_last;

    assign wr_ready   = (w_fifo_count < c_CNT_W'(FIFO_DEPTH));
    assign w_push     = wr_valid & ~w_fifo_full;
    // Reads always win; the FIFO drains only in IDLE, the clear only in CLEAR.
    assign w_pop      = ~rd_req & (r_state == ST_IDLE) & ~w_fifo_empty;
    assign w_clr_wr   = ~rd_req & (r_state == ST_CLEAR);
    assign w_clr_last = w_clr_wr & (r_clr_ptr == c_LAST_ADDR);
    assign w_wr_last  = w_pop & (r_wr_ptr == c_LAST_ADDR);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (clear_start) w_next_state = ST_CLEAR;
            ST_CLEAR: if (w_clr_last)  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        busy      = (r_state == ST_CLEAR);
        if (rd_req) begin
            ram_addr = rd_addr;
        end else if (w_pop) begin
            ram_addr  = r_wr_ptr;
            ram_we    = 1'b1;
            ram_wdata = w_fifo_head;
        end else if (w_clr_wr) begin
            ram_addr  = r_clr_ptr;
            ram_we    = 1'b1;
            ram_wdata = CLEAR_VALUE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_clr_ptr    <= '0;
            r_frame_done <= 1'b0;
            r_clear_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Restart and clear completion override the pop increment; the
            // popped word has already been addressed with the old pointer.
            if (w_clr_last || frame_restart) begin
                r_wr_ptr <= '0;
            end else if (w_pop) begin
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + ADDR_W'(1);
            end
            if ((r_state == ST_IDLE) && clear_start) begin
                r_clr_ptr <= '0;
            end else if (w_clr_wr) begin
                r_clr_ptr <= w_clr_last ? '0 : r_clr_ptr + ADDR_W'(1);
            end
            r_frame_done <= w_wr_last;
            r_clear_done <= w_clr_last;
            if (wr_valid && !wr_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pend  <= rd_req;
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= ram_rdata;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign wr_addr    = r_wr_ptr;
    assign frame_done = r_frame_done;
    assign clear_done = r_clear_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_port_sched
// Description : Directed self-checking bench for vram_port_sched (8-word frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_port_sched;

    localparam logic [23:0] c_CLR = 24'h0A0B0C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic [23:0] wr_data = '0;
    logic        wr_ready;
    logic        frame_restart = 1'b0;
    logic        clear_start = 1'b0;
    logic        rd_req = 1'b0;
    logic [14:0] rd_addr = '0;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;
    logic [14:0] wr_addr;
    logic        busy;
    logic        frame_done;
    logic        clear_done;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_cnt   = 0;
    int fd_cyc   = 0;
    int cd_cnt   = 0;

    logic [23:0] mem [0:32767];
    logic [14:0] log_a [$];
    logic [23:0] log_d [$];
    int          log_c [$];

    vram_port_sched #(
        .FRAME_WORDS (8),
        .CLEAR_VALUE (c_CLR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .frame_restart (frame_restart),
        .clear_start   (clear_start),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .wr_addr       (wr_addr),
        .busy          (busy),
        .frame_done    (frame_done),
        .clear_done    (clear_done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model, read-before-write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (reset) begin
            if (ram_we) begin
                log_a.push_back(ram_addr);
                log_d.push_back(ram_wdata);
                log_c.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (clear_done) cd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            rd_req = 1'b1; rd_addr = 15'(k);
            wr_valid = (k < 5); wr_data = 24'hEE0000 + 24'(k);
            tick();
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_overflow got=%b exp=1", overflow); end
        reset = 1'b0;
        tick(); tick();
        rd_req = 1'b0; wr_valid = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        n_checks++;
        if (wr_addr !== 15'd0) begin n_fail++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got=%b exp=0 (fifo not empty)", ram_we); end
    endtask

    task automatic test_idle_write();
        logic [23:0] w [3];
        w[0] = 24'hAAAAAA; w[1] = 24'hBBBBBB; w[2] = 24'hCCCCCC;
        clear_log();
        for (int k = 0; k < 6; k++) begin
            wr_valid = (k < 3); wr_data = (k < 3) ? w[k] : '0;
            tick();
        end
        n_checks++;
        if (log_a.size() !== 3) begin n_fail++; $display("FAIL idle_write_count got=%0d exp=3", log_a.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (log_a[i] !== 15'(i) || log_d[i] !== w[i])
                begin n_fail++; $display("FAIL idle_write_%0d got=%0d/%h exp=%0d/%h", i, log_a[i], log_d[i], i, w[i]); end
            end
            n_checks++;
            if (log_c[1] != log_c[0] + 1 || log_c[2] != log_c[1] + 1)
            begin n_fail++; $display("FAIL idle_write_consecutive got cycles=%0d,%0d,%0d", log_c[0], log_c[1], log_c[2]); end
        end
        n_checks++;
        if (wr_addr !== 15'd3) begin n_fail++; $display("FAIL idle_wr_addr got=%0d exp=3", wr_addr); end
    endtask

    task automatic test_read_priority();
        logic [23:0] w [5];
        logic [23:0] rexp [3];
        rexp[0] = 24'hAAAAAA; rexp[1] = 24'hBBBBBB; rexp[2] = 24'hCCCCCC;
        for (int i = 0; i < 5; i++) w[i] = 24'h550000 + 24'(i + 1);
        frame_restart = 1'b1; tick(); frame_restart = 1'b0;
        n_checks++;
        if (wr_addr !== 15'd0) begin n_fail++; $display("FAIL restart_wr_addr got=%0d exp=0", wr_addr); end
        clear_log();
        for (int j = 0; j < 10; j++) begin
            if (j <= 8) begin
                n_checks++;
                if (rd_valid !== (j >= 2 && j <= 7))
                begin n_fail++; $display("FAIL rd_valid_cyc%0d got=%b exp=%b", j, rd_valid, (j >= 2 && j <= 7)); end
            end
            if (j >= 2 && j <= 4) begin
                n_checks++;
                if (rd_data !== rexp[j-2]) begin n_fail++; $display("FAIL rd_data_%0d got=%h exp=%h", j - 2, rd_data, rexp[j-2]); end
            end
            if (j <= 4) begin
                n_checks++;
                if (wr_ready !== (j < 4)) begin n_fail++; $display("FAIL rp_wr_ready_cyc%0d got=%b exp=%b", j, wr_ready, (j < 4)); end
            end
            if (j == 4 || j == 5) begin
                n_checks++;
                if (overflow !== (j == 5)) begin n_fail++; $display("FAIL rp_overflow_cyc%0d got=%b exp=%b", j, overflow, (j == 5)); end
            end
            if (j == 6) begin
                n_checks++;
                if (log_a.size() !== 0) begin n_fail++; $display("FAIL rp_write_during_read got=%0d writes exp=0", log_a.size()); end
            end
            rd_req = (j < 6); rd_addr = 15'(j);
            wr_valid = (j < 5); wr_data = (j < 5) ? w[j] : '0;
            tick();
        end
        n_checks++;
        if (log_a.size() !== 4) begin n_fail++; $display("FAIL rp_drain_count got=%0d exp=4", log_a.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_a[i] !== 15'(i) || log_d[i] !== w[i])
                begin n_fail++; $display("FAIL rp_drain_%0d got=%0d/%h exp=%0d/%h", i, log_a[i], log_d[i], i, w[i]); end
            end
        end
        n_checks++;
        if (wr_addr !== 15'd4) begin n_fail++; $display("FAIL rp_wr_addr got=%0d exp=4", wr_addr); end
    endtask

    task automatic test_wrap();
        frame_restart = 1'b1; tick(); frame_restart = 1'b0;
        clear_log();
        fd_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            wr_valid = (k < 9); wr_data = 24'h300000 + 24'(k);
            tick();
        end
        n_checks++;
        if (log_a.size() !== 9) begin n_fail++; $display("FAIL wrap_count got=%0d exp=9", log_a.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (log_a[i] !== 15'(i)) begin n_fail++; $display("FAIL wrap_addr_%0d got=%0d exp=%0d", i, log_a[i], i); end
            end
            n_checks++;
            if (log_a[8] !== 15'd0 || log_d[8] !== 24'h300008)
            begin n_fail++; $display("FAIL wrap_ninth got=%0d/%h exp=0/300008", log_a[8], log_d[8]); end
            n_checks++;
            if (fd_cyc != log_c[7] + 1) begin n_fail++; $display("FAIL frame_done_cycle got=%0d exp=%0d", fd_cyc, log_c[7] + 1); end
        end
        n_checks++;
        if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
        n_checks++;
        if (wr_addr !== 15'd1) begin n_fail++; $display("FAIL wrap_wr_addr got=%0d exp=1", wr_addr); end
    endtask

    task automatic test_restart_collision();
        clear_log();
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_data = (k < 4) ? 24'h400000 + 24'(k) : 24'h5A5A5A;
            tick();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (wr_addr !== 15'd5) begin n_fail++; $display("FAIL rc_pre_addr got=%0d exp=5", wr_addr); end
        frame_restart = 1'b1;
        tick();
        frame_restart = 1'b0;
        n_checks++;
        if (log_a.size() == 0 || log_a[log_a.size()-1] !== 15'd5 || log_d[log_d.size()-1] !== 24'h5A5A5A)
        begin n_fail++; $display("FAIL rc_collision_write got=%0d entries, last addr=%0d exp=5/5a5a5a", log_a.size(), (log_a.size() == 0) ? 0 : log_a[log_a.size()-1]); end
        n_checks++;
        if (wr_addr !== 15'd0) begin n_fail++; $display("FAIL rc_post_addr got=%0d exp=0", wr_addr); end
        wr_valid = 1'b1; wr_data = 24'h6B6B6B;
        tick();
        wr_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (log_a[log_a.size()-1] !== 15'd0 || log_d[log_d.size()-1] !== 24'h6B6B6B)
        begin n_fail++; $display("FAIL rc_next_write got=%0d/%h exp=0/6b6b6b", log_a[log_a.size()-1], log_d[log_d.size()-1]); end
    endtask

    task automatic test_clear();
        clear_log();
        cd_cnt = 0;
        for (int k = 0; k < 23; k++) begin
            n_checks++;
            if (busy !== (k >= 1 && k <= 16)) begin n_fail++; $display("FAIL busy_cyc%0d got=%b exp=%b", k, busy, (k >= 1 && k <= 16)); end
            if (k == 17) begin
                n_checks++;
                if (clear_done !== 1'b1) begin n_fail++; $display("FAIL clear_done_cyc17 got=%b exp=1", clear_done); end
                n_checks++;
                if (wr_addr !== 15'd0) begin n_fail++; $display("FAIL clear_wr_addr got=%0d exp=0", wr_addr); end
            end
            clear_start = (k == 0 || k == 5);
            rd_req = (k >= 1 && k <= 16 && (k % 2 == 1)); rd_addr = 15'(k % 8);
            wr_valid = (k == 1 || k == 2); wr_data = (k == 1) ? 24'hD1D1D1 : 24'hD2D2D2;
            tick();
        end
        clear_start = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
        n_checks++;
        if (log_a.size() !== 10) begin n_fail++; $display("FAIL clear_write_count got=%0d exp=10", log_a.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (log_a[i] !== 15'(i) || log_d[i] !== c_CLR)
                begin n_fail++; $display("FAIL clear_word_%0d got=%0d/%h exp=%0d/%h", i, log_a[i], log_d[i], i, c_CLR); end
            end
            n_checks++;
            if (log_a[8] !== 15'd0 || log_d[8] !== 24'hD1D1D1 || log_a[9] !== 15'd1 || log_d[9] !== 24'hD2D2D2)
            begin n_fail++; $display("FAIL clear_drain got=%0d/%h %0d/%h exp=0/d1d1d1 1/d2d2d2", log_a[8], log_d[8], log_a[9], log_d[9]); end
        end
        n_checks++;
        if (cd_cnt != 1) begin n_fail++; $display("FAIL clear_done_count got=%0d exp=1", cd_cnt); end
    endtask

    initial begin
        reset = 1'b0;
        tick(); tick(); tick();
        test_reset();
        test_idle_write();
        test_read_priority();
        test_wrap();
        test_restart_collision();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_port_sched.md
# vram_port_sched

Single-port scheduler for the 24-bit frame RAM behind the VGA serial display. It shares one synchronous-read RAM port between the VGA pixel reader, which has absolute priority, and the serial pixel writer, whose assembled words are buffered in a small FIFO and drained into free cycles. It owns the write-address counter with wrap-around, and it runs a whole-frame clear sequence on request.

## Interface
Parameters:
- ADDR_W, 15: RAM address width.
- DATA_W, 24: pixel word width (RGB 8:8:8).
- FRAME_WORDS, 19200: number of words per frame; addresses 0..FRAME_WORDS-1.
- FIFO_DEPTH, 4: write buffer depth, power of two.
- CLEAR_VALUE, 24'h000000: word written during clear.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  assembled pixel word present.
- wr_data  in  DATA_W  pixel word.
- wr_ready  out  1  FIFO can accept; high when count < FIFO_DEPTH.
- frame_restart  in  1  pulse; write pointer returns to 0.
- clear_start  in  1  pulse; start a whole-frame clear.
- rd_req  in  1  VGA read request this cycle.
- rd_addr  in  ADDR_W  VGA read address.
- rd_data  out  DATA_W  read result.
- rd_valid  out  1  rd_data valid.
- ram_addr  out  ADDR_W  RAM address (combinational).
- ram_we  out  1  RAM write enable (combinational).
- ram_wdata  out  DATA_W  RAM write data (combinational).
- ram_rdata  in  DATA_W  RAM read data, one cycle after the address is sampled.
- wr_addr  out  ADDR_W  current write pointer.
- busy  out  1  high in CLEAR.
- frame_done  out  1  one-cycle pulse after the word at FRAME_WORDS-1 is written.
- clear_done  out  1  one-cycle pulse when the clear completes.
- overflow  out  1  sticky; set when wr_valid=1 while wr_ready=0.

## Operation
- States: IDLE, CLEAR.
- Exactly one RAM access per cycle. Priority order:
  - rd_req: ram_addr=rd_addr, ram_we=0.
  - IDLE and FIFO non-empty: pop the FIFO; ram_addr=wr_ptr, ram_we=1, ram_wdata=FIFO head.
  - CLEAR: ram_addr=clr_ptr, ram_we=1, ram_wdata=CLEAR_VALUE.
  - Otherwise: ram_we=0, ram_addr=0.
- FIFO push when wr_valid & wr_ready. A word offered while wr_ready=0 is dropped and sets overflow, which stays set until reset.
- Pushes are accepted during CLEAR, but the FIFO is not drained until the block returns to IDLE.
- wr_ptr increments after each FIFO write.
  - At FRAME_WORDS-1 it wraps to 0 and frame_done pulses the next cycle.
  - Counter arithmetic is ADDR_W bits unsigned with an explicit wrap compare, not power-of-two rollover.
- frame_restart sets wr_ptr=0 at the next edge.
  - It wins over a simultaneous increment.
  - A word popped in that same cycle is written at the old pointer.
- clear_start in IDLE sets clr_ptr=0 and enters CLEAR.
  - clear_start is ignored while in CLEAR.
  - clr_ptr advances only on cycles with no rd_req.
  - After the write at FRAME_WORDS-1: return to IDLE, pulse clear_done, set wr_ptr=0.

## Timing
- Reset values:
  - Registered outputs rd_data, rd_valid, frame_done, clear_done, overflow, busy and wr_addr are 0.
  - wr_ready is 1.
  - state=IDLE, FIFO empty.
- Read latency is 2:
  - rd_req is sampled in cycle N.
  - RAM data arrives in cycle N+1 and is registered.
  - rd_valid=1 and rd_data are presented in cycle N+2.
- Back-to-back rd_req gives one rd_valid per cycle.
- Write-through latency: a push at edge E can reach the RAM no earlier than the cycle following E.
- Push and pop in the same cycle with a non-full FIFO: count unchanged.
- At full, wr_ready=0 regardless of a same-cycle pop.
- Continuous rd_req starves writes. The FIFO fills and overflow records any loss; no starvation override.
- Reset mid-CLEAR abandons the clear. The RAM contents are undefined for the region not yet cleared.

## Structure
- vram_pkg holds the state enum typedef and the default DATA_W and ADDR_W localparams shared with the serial assembler and the VGA reader.
- Sub-module sync_fifo: parameterised width and depth; push, pop, full, empty, count.
- Scheduler FSM, pointers and read pipeline live in vram_port_sched.

## Test plan
- Reset state: reset=0 mid-traffic, then release. Required: wr_ready=1, wr_addr=0, overflow=0, rd_valid=0, busy=0.
- Idle write: push 3 words A, B, C with no reads. Required: RAM writes at 0, 1, 2 on consecutive cycles; wr_addr=3.
- Read priority: rd_req held 6 cycles while pushing 5 words. Required:
  - no RAM writes during the reads;
  - wr_ready drops after 4 words and overflow sets on the 5th;
  - afterwards words 1-4 land at 0..3;
  - rd_valid pulses 2 cycles after each request.
- Wrap: FRAME_WORDS=8. Push 9 words. Required: the 9th word lands at address 0, and frame_done pulses once, the cycle after the write at address 7.
- Restart collision: frame_restart asserted on the cycle a word pops at wr_ptr=5. Required: the word is written at 5, then wr_addr=0.
- Clear with interleaved reads: FRAME_WORDS=8, clear_start, rd_req on alternate cycles. Required:
  - 8 CLEAR_VALUE writes to 0..7 with no skipped or duplicated address;
  - busy is high throughout;
  - clear_done pulses once and wr_addr=0;
  - FIFO contents pushed during the clear drain afterwards.
